strhw_e_sched: RTL
==================

Name: strhw_e_sched

Overview:
- Sequencer for the Streebog E(K, m) transform used inside the compression function g_N.
- Time-shares one external combinational LPS unit (S-box, byte transpose P, linear L) between the state path and the key-schedule path.
- Runs 12 rounds (24 LPS passes) and applies the final key XOR.
- Fetches round constants C_0..C_11 by index from an external constant ROM; sits between the g_N controller and the shared LPS datapath.

Parameters:
ROUNDS, 12, number of LSX rounds; constant-index width is $clog2(ROUNDS).

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
in_valid_i  in  1  K/m pair offered
in_ready_o  out  1  block idle, can accept
k_i  in  512  initial key K_1
m_i  in  512  message/state input
lps_a_o  out  512  operand driven to shared LPS unit
lps_result_i  in  512  LPS(lps_a_o), combinational return
rc_idx_o  out  4  round-constant index into constant ROM
rc_i  in  512  C[rc_idx_o], combinational return
out_valid_o  out  1  result valid
out_ready_i  in  1  downstream accepts result
result_o  out  512  E(K, m)

Behaviour:
- Reset (async, rst_ni low): state=IDLE, in_ready_o=1, out_valid_o=0, result_o=0, rc_idx_o=0, lps_a_o=0, internal state/key registers=0.
- Reset mid-operation aborts immediately; no result is produced.
- FSM states: IDLE, ST (state step), KS (key step), DONE.
- IDLE: in_ready_o=1. On in_valid_i&&in_ready_o: st_q<=m_i, k_q<=k_i, rnd<=0, go to ST.
- ST: lps_a_o=st_q^k_q. Edge: st_q<=lps_result_i, go to KS.
- KS: lps_a_o=k_q^rc_i, rc_idx_o=rnd.
  - Edge with rnd<ROUNDS-1: k_q<=lps_result_i, rnd<=rnd+1, go to ST.
  - Edge with rnd==ROUNDS-1: result_o<=st_q^lps_result_i (final X[K13]), out_valid_o<=1, go to DONE.
- DONE: result_o and out_valid_o held stable until out_ready_i. On out_valid_o&&out_ready_i: out_valid_o<=0, go to IDLE (in_ready_o=1 the following cycle).
- No input accept in the handshake cycle.
- Latency: out_valid_o rises exactly 2*ROUNDS=24 edges after the accepting edge. Throughput: one block per 26 cycles with out_ready_i tied high.
- lps_a_o is 0 in IDLE/DONE (limits toggling). rc_idx_o is 0 outside KS.
- in_ready_o=0 in ST/KS/DONE; in_valid_i is ignored then and k_i/m_i may change freely.
- out_ready_i asserted before out_valid_o has no effect.
- All arithmetic is bitwise XOR, full 512 bits, no truncation.

Optional Feature:
STRHW_E_SCHED_PERF_EN:
- Defined: adds output perf_blocks_o[31:0]. Counts completed output handshakes, saturates at 32'hFFFF_FFFF, cleared by reset.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst_ni=0 mid-KS at round 5 -> out_valid_o=0, in_ready_o=1, result_o=0 asynchronously. After release, next block completes with correct value.
- Identity LPS stub (lps_result_i=lps_a_o), rc_i=rc_idx_o+1, k_i=m_i=512'h1234 -> result_o=512'h0E. rc_idx_o sequence in KS cycles is 0,1,…,11.
- Latency/handshake: accept at edge T, out_ready_i=1 -> out_valid_o first high after edge T+24. in_ready_o returns high after edge T+25.
- Backpressure: hold out_ready_i=0 for 10 cycles after out_valid_o -> result_o stable, in_ready_o=0, in_valid_i pulses ignored. Release -> one handshake only.
- Real LPS + constant ROM: K=0, m=0; random K/m x100 -> result_o matches software E(K,m) golden model. First ST cycle lps_a_o=m^K.
- PERF_EN build: 3 back-to-back blocks -> perf_blocks_o=3. Force counter to 32'hFFFF_FFFF, complete a block -> stays 32'hFFFF_FFFF.

Source files
------------

// File: rtl/strhw_e_sched.sv
// Streebog E(K, m) sequencer: alternates state and key LPS passes on one shared LPS unit.
// Optional STRHW_E_SCHED_PERF_EN adds perf_blocks_o, a saturating count of delivered results.
module strhw_e_sched #(
    parameter  int unsigned ROUNDS = 12,
    localparam int unsigned IDX_W  = $clog2(ROUNDS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [511:0]     k_i,
    input  logic [511:0]     m_i,
    output logic [511:0]     lps_a_o,
    input  logic [511:0]     lps_result_i,
    output logic [IDX_W-1:0] rc_idx_o,
    input  logic [511:0]     rc_i,
`ifdef STRHW_E_SCHED_PERF_EN
    output logic [31:0]      perf_blocks_o,
`endif
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [511:0]     result_o
);

    localparam int unsigned DW = 512;
    localparam logic [IDX_W-1:0] LAST_RND = IDX_W'(ROUNDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ST   = 2'd1,
        S_KS   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    logic [DW-1:0]     r_st;
    logic [DW-1:0]     r_k;
    logic [DW-1:0]     r_result;
    logic [IDX_W-1:0]  r_rnd;
    logic [IDX_W-1:0]  r_rc_idx;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [DW-1:0]     w_lps_a;
    logic              w_out_hs;

    assign w_out_hs = r_out_valid && out_ready_i;

    // LPS operand mux; zero when idle or holding to keep the shared unit quiet.
    always_comb begin
        w_lps_a = '0;
        case (r_state)
            S_ST:    w_lps_a = r_st ^ r_k;
            S_KS:    w_lps_a = r_k ^ rc_i;
            default: w_lps_a = '0;
        endcase
    end

    // Sequencer: ST updates the state, KS advances the key; the last KS folds in K13.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_st        <= '0;
            r_k         <= '0;
            r_result    <= '0;
            r_rnd       <= '0;
            r_rc_idx    <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid_i && r_in_ready) begin
                        r_st       <= m_i;
                        r_k        <= k_i;
                        r_rnd      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_ST;
                    end
                end
                S_ST: begin
                    r_st     <= lps_result_i;
                    r_rc_idx <= r_rnd;
                    r_state  <= S_KS;
                end
                S_KS: begin
                    r_rc_idx <= '0;
                    if (r_rnd == LAST_RND) begin
                        r_result    <= r_st ^ lps_result_i;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_k     <= lps_result_i;
                        r_rnd   <= r_rnd + IDX_W'(1);
                        r_state <= S_ST;
                    end
                end
                S_DONE: begin
                    if (w_out_hs) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef STRHW_E_SCHED_PERF_EN
    logic [31:0] r_perf_blocks;

    // Saturating count of output handshakes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_perf_blocks <= '0;
        end else if (w_out_hs && (r_perf_blocks != 32'hFFFF_FFFF)) begin
            r_perf_blocks <= r_perf_blocks + 32'd1;
        end
    end

    assign perf_blocks_o = r_perf_blocks;
`endif

    assign in_ready_o  = r_in_ready;
    assign out_valid_o = r_out_valid;
    assign result_o    = r_result;
    assign rc_idx_o    = r_rc_idx;
    assign lps_a_o     = w_lps_a;

endmodule
